// File: rtl/median_frame_sequencer_if.sv
// Bundles the source, filter and destination signals of the frame sequencer.
// master = sequencer side, slave = sources/filter/sinks around it.
interface median_frame_sequencer_if #(
    parameter int DATA_W = 8
);
    logic [1:0]          src_req;
    logic [1:0]          src_pix_valid;
    logic [2*DATA_W-1:0] src_pix_data;
    logic [1:0]          src_grant;
    logic                filt_frame_sync_in;
    logic [DATA_W-1:0]   filt_data_in;
    logic                filt_frame_sync_out;
    logic [DATA_W-1:0]   filt_data_out;
    logic [1:0]          dst_valid;
    logic [DATA_W-1:0]   dst_data;
    logic                dst_sof;
    logic                dst_eof;
    logic [2:0]          err;
    logic                err_clr;
    logic                busy;

    modport master (
        input  src_req, src_pix_valid, src_pix_data, filt_frame_sync_out, filt_data_out, err_clr,
        output src_grant, filt_frame_sync_in, filt_data_in, dst_valid, dst_data, dst_sof, dst_eof,
               err, busy
    );

    modport slave (
        output src_req, src_pix_valid, src_pix_data, filt_frame_sync_out, filt_data_out, err_clr,
        input  src_grant, filt_frame_sync_in, filt_data_in, dst_valid, dst_data, dst_sof, dst_eof,
               err, busy
    );
endinterface

// File: rtl/median_frame_sequencer.sv
// Shares one median filter between two pixel sources by granting whole frames,
// tagging each launched frame and routing the filtered frame back to its owner.
module median_frame_sequencer #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    median_frame_sequencer_if.master bus
);
    localparam int IMG_SIZE = IMG_W * IMG_H;
    localparam int CNT_W    = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(IMG_SIZE - 1);

    typedef enum logic {IN_IDLE, STREAM}      in_state_t;
    typedef enum logic {OUT_IDLE, OUT_ACTIVE} out_state_t;

    in_state_t         in_state_reg;
    out_state_t        out_state_reg;
    logic [CNT_W-1:0]  in_cnt_reg, out_cnt_reg;
    logic              grant_idx_reg, rr_last_reg, out_tag_reg;
    logic [1:0]        src_grant_reg, dst_valid_reg;
    logic              filt_sync_reg, dst_sof_reg, dst_eof_reg;
    logic [DATA_W-1:0] filt_data_reg, dst_data_reg;
    logic [2:0]        err_reg;
    logic              tag_mem_reg [2];
    logic              wr_ptr_reg, rd_ptr_reg;
    logic [1:0]        fifo_cnt_reg;

    logic [DATA_W-1:0] pix_arr [2];
    logic              fifo_empty, fifo_full, push, pop, win, head_tag;
    logic              sel_valid, underrun, orphan, truncate;
    logic              emit, emit_tag;
    logic [CNT_W-1:0]  emit_idx;

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_src
        assign pix_arr[gi] = bus.src_pix_data[gi*DATA_W +: DATA_W];
    end

    assign fifo_empty = (fifo_cnt_reg == 2'd0);
    assign fifo_full  = (fifo_cnt_reg == 2'd2);
    assign head_tag   = tag_mem_reg[rd_ptr_reg];
    assign pop        = bus.filt_frame_sync_out && !fifo_empty;
    // A pop in the same cycle frees the slot a new tag needs, so a full FIFO may still grant.
    assign push       = (in_state_reg == IN_IDLE) && (|bus.src_req) && (!fifo_full || pop);
    assign win        = (bus.src_req == 2'b11) ? ~rr_last_reg : bus.src_req[1];
    assign sel_valid  = bus.src_pix_valid[grant_idx_reg];
    assign underrun   = (in_state_reg == STREAM) && !sel_valid;
    assign orphan     = bus.filt_frame_sync_out && fifo_empty;
    assign truncate   = bus.filt_frame_sync_out && (out_state_reg == OUT_ACTIVE) && (out_cnt_reg != '0);

    // Output pixel of this cycle: a sync with a waiting tag restarts at index 0.
    always_comb begin
        emit     = pop || ((out_state_reg == OUT_ACTIVE) && !bus.filt_frame_sync_out);
        emit_idx = pop ? '0 : out_cnt_reg;
        emit_tag = pop ? head_tag : out_tag_reg;
    end

    for (gi = 0; gi < 2; gi++) begin : g_tag
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                tag_mem_reg[gi] <= 1'b0;
            else if (push && (wr_ptr_reg == 1'(gi)))
                tag_mem_reg[gi] <= win;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            fifo_cnt_reg <= 2'd0;
        end else begin
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
            case ({push, pop})
                2'b10:   fifo_cnt_reg <= fifo_cnt_reg + 2'd1;
                2'b01:   fifo_cnt_reg <= fifo_cnt_reg - 2'd1;
                default: fifo_cnt_reg <= fifo_cnt_reg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_state_reg  <= IN_IDLE;
            in_cnt_reg    <= '0;
            grant_idx_reg <= 1'b0;
            rr_last_reg   <= 1'b1;
            src_grant_reg <= 2'b00;
            filt_data_reg <= '0;
            filt_sync_reg <= 1'b0;
        end else begin
            filt_data_reg <= '0;
            filt_sync_reg <= 1'b0;
            case (in_state_reg)
                IN_IDLE: begin
                    if (push) begin
                        grant_idx_reg <= win;
                        rr_last_reg   <= win;
                        src_grant_reg <= win ? 2'b10 : 2'b01;
                        in_cnt_reg    <= '0;
                        in_state_reg  <= STREAM;
                    end
                end
                STREAM: begin
                    filt_data_reg <= sel_valid ? pix_arr[grant_idx_reg] : '0;
                    filt_sync_reg <= (in_cnt_reg == '0);
                    if (in_cnt_reg == LAST) begin
                        in_cnt_reg    <= '0;
                        src_grant_reg <= 2'b00;
                        in_state_reg  <= IN_IDLE;
                    end else begin
                        in_cnt_reg <= in_cnt_reg + 1'b1;
                    end
                end
                default: in_state_reg <= IN_IDLE;
            endcase
        end
    end

    // out_cnt_reg holds the index of the next expected filter pixel while OUT_ACTIVE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_state_reg <= OUT_IDLE;
            out_cnt_reg   <= '0;
            out_tag_reg   <= 1'b0;
            dst_valid_reg <= 2'b00;
            dst_data_reg  <= '0;
            dst_sof_reg   <= 1'b0;
            dst_eof_reg   <= 1'b0;
            err_reg       <= 3'b000;
        end else begin
            err_reg       <= (bus.err_clr ? 3'b000 : err_reg) | {truncate, orphan, underrun};
            dst_valid_reg <= emit ? (emit_tag ? 2'b10 : 2'b01) : 2'b00;
            dst_data_reg  <= emit ? bus.filt_data_out : '0;
            dst_sof_reg   <= emit && (emit_idx == '0);
            dst_eof_reg   <= emit && (emit_idx == LAST);
            if (emit) begin
                out_tag_reg <= emit_tag;
                if (emit_idx == LAST) begin
                    out_cnt_reg   <= '0;
                    out_state_reg <= OUT_IDLE;
                end else begin
                    out_cnt_reg   <= emit_idx + 1'b1;
                    out_state_reg <= OUT_ACTIVE;
                end
            end else if (bus.filt_frame_sync_out) begin
                out_cnt_reg   <= '0;
                out_state_reg <= OUT_IDLE;
            end
        end
    end

    assign bus.src_grant          = src_grant_reg;
    assign bus.filt_frame_sync_in = filt_sync_reg;
    assign bus.filt_data_in       = filt_data_reg;
    assign bus.dst_valid          = dst_valid_reg;
    assign bus.dst_data           = dst_data_reg;
    assign bus.dst_sof            = dst_sof_reg;
    assign bus.dst_eof            = dst_eof_reg;
    assign bus.err                = err_reg;
    assign bus.busy               = (in_state_reg == STREAM) || !fifo_empty || (out_state_reg == OUT_ACTIVE);
endmodule

// File: tb/tb_median_frame_sequencer.sv
// Drives two random pixel sources and a fixed-latency pass-through filter model;
// expected frames are queued at grant time and checked by an independent output monitor.
`timescale 1ns/1ps
module tb_median_frame_sequencer;
    localparam int IMG_W = 4, IMG_H = 4, DATA_W = 8, N = IMG_W * IMG_H, LAT = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    median_frame_sequencer_if #(.DATA_W(DATA_W)) bus ();
    median_frame_sequencer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(rst), .bus(bus)
    );

    typedef struct packed {
        logic                    owner;
        logic [N-1:0][DATA_W-1:0] pix;
    } frame_t;

    frame_t exp_q[$];
    int n_checks = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // ---------------- source + filter environment ----------------
    int req_total [2] = '{0, 0};
    int granted_cnt [2] = '{0, 0};
    int cur = -1, pidx = 0, cur_inv = -1, rr_m = 1;
    int granted_total = 0, popped_total = 0, sync_in_total = 0;
    int inject_req = 0, inject_done = 0, withheld = 0, max_out = 0;
    int inv_frame_no = -1, inv_idx = 0, since_reset = 0, first_owner = -1;
    logic [DATA_W-1:0] drive_pix [N];
    logic              pipe_s [LAT];
    logic [DATA_W-1:0] pipe_d [LAT];
    logic [1:0]        g_s;
    int                w_s, exp_w;
    frame_t            f_s;
    logic              out_s;
    logic [DATA_W-1:0] out_d;

    always @(negedge clk) begin
        if (rst) begin
            cur = -1; pidx = 0; rr_m = 1; since_reset = 0;
            popped_total = granted_total;
            inject_done = inject_req;
            exp_q.delete();
            for (int n = 0; n < 2; n++) granted_cnt[n] = req_total[n];
            for (int i = 0; i < LAT; i++) begin pipe_s[i] = 1'b0; pipe_d[i] = '0; end
            bus.src_req = 2'b00; bus.src_pix_valid = 2'b00; bus.src_pix_data = '0;
            bus.filt_frame_sync_out = 1'b0; bus.filt_data_out = '0;
        end else begin
            g_s = bus.src_grant;
            chk("grant_onehot", {30'd0, g_s & (g_s - 2'd1)}, 0);
            if (cur >= 0) begin
                if (pidx == N) begin
                    chk("grant_gap", {30'd0, g_s}, 0);
                    cur = -1;
                end else begin
                    chk("grant_hold", {30'd0, g_s}, (cur == 1) ? 2 : 1);
                end
            end
            if (cur < 0 && g_s != 2'b00) begin
                w_s = g_s[1] ? 1 : 0;
                exp_w = (bus.src_req == 2'b11) ? (rr_m ^ 1) : (bus.src_req[1] ? 1 : 0);
                chk("grant_had_req", {31'd0, bus.src_req[w_s]}, 1);
                chk("grant_owner", w_s, exp_w);
                chk("fifo_room", {31'd0, (granted_total - popped_total) <= 1}, 1);
                cur_inv = (granted_total == inv_frame_no) ? inv_idx : -1;
                rr_m = w_s;
                granted_total++; granted_cnt[w_s]++;
                if (since_reset == 0) first_owner = w_s;
                since_reset++;
                if (granted_total - popped_total > max_out) max_out = granted_total - popped_total;
                f_s.owner = exp_w[0];
                for (int i = 0; i < N; i++) begin
                    drive_pix[i] = DATA_W'($urandom);
                    f_s.pix[i] = (i == cur_inv) ? '0 : drive_pix[i];
                end
                exp_q.push_back(f_s);
                cur = w_s; pidx = 0;
                $display("grant src%0d frame %0d t=%0t", w_s, granted_total, $time);
            end
            bus.src_pix_valid = 2'b00;
            bus.src_pix_data  = 16'($urandom);
            if (cur >= 0 && pidx < N) begin
                bus.src_pix_valid[cur] = (pidx != cur_inv);
                bus.src_pix_data[cur*DATA_W +: DATA_W] = drive_pix[pidx];
                pidx++;
            end
            for (int n = 0; n < 2; n++) bus.src_req[n] = (req_total[n] > granted_cnt[n]);

            if (bus.filt_frame_sync_in) sync_in_total++;
            out_s = pipe_s[LAT-1]; out_d = pipe_d[LAT-1];
            for (int i = LAT - 1; i > 0; i--) begin pipe_s[i] = pipe_s[i-1]; pipe_d[i] = pipe_d[i-1]; end
            pipe_s[0] = bus.filt_frame_sync_in; pipe_d[0] = bus.filt_data_in;
            if (inject_req != inject_done) begin
                out_s = 1'b1; out_d = 8'hA5; inject_done++;
            end else if (out_s) begin
                popped_total++;
            end
            bus.filt_frame_sync_out = out_s; bus.filt_data_out = out_d;
            if (cur < 0 && bus.src_req != 2'b00 && (granted_total - popped_total) >= 2) withheld++;
        end
    end

    // ---------------- output monitor ----------------
    frame_t mf;
    int mon_active = 0, mon_idx = 0, frames_done = 0;

    always @(negedge clk) begin
        if (rst) begin
            mon_active = 0; mon_idx = 0;
        end else if (bus.dst_valid != 2'b00) begin
            if (bus.dst_sof) begin
                if (mon_active != 0) chk("frame_len_before_sof", mon_idx, N);
                mon_active = 0;
                if (exp_q.size() == 0) chk("dst_unexpected_sof", {30'd0, bus.dst_valid}, 0);
                else begin mf = exp_q.pop_front(); mon_active = 1; mon_idx = 0; end
            end
            if (mon_active != 0) begin
                chk("dst_owner", {30'd0, bus.dst_valid}, mf.owner ? 2 : 1);
                chk("dst_data", {24'd0, bus.dst_data}, {24'd0, mf.pix[mon_idx]});
                chk("dst_sof", {31'd0, bus.dst_sof}, {31'd0, mon_idx == 0});
                chk("dst_eof", {31'd0, bus.dst_eof}, {31'd0, mon_idx == N - 1});
                mon_idx++;
                if (mon_idx == N) begin
                    mon_active = 0; frames_done++;
                    $display("frame %0d delivered to src%0d t=%0t", frames_done, mf.owner, $time);
                end
            end else if (!bus.dst_sof) begin
                chk("dst_stray", {30'd0, bus.dst_valid}, 0);
            end
        end else if (mon_active != 0) begin
            chk("dst_contiguous", {30'd0, bus.dst_valid}, mf.owner ? 2 : 1);
        end
    end

    // ---------------- sequence ----------------
    task automatic wait_idle(input int budget);
        int n = 0, quiet = 0;
        while (quiet < 3 && n < budget) begin
            @(negedge clk); #1; n++;
            if (bus.src_req == 2'b00 && cur < 0 && !bus.busy && exp_q.size() == 0 &&
                mon_active == 0 && inject_req == inject_done) quiet++;
            else quiet = 0;
        end
        chk("idle_timeout", {31'd0, quiet >= 3}, 1);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 bus.err_clr = 1'b1;
        @(posedge clk); #1 bus.err_clr = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_grant"}, {30'd0, bus.src_grant}, 0);
        chk({tag, "_dst_valid"}, {30'd0, bus.dst_valid}, 0);
        chk({tag, "_dst_data"}, {24'd0, bus.dst_data}, 0);
        chk({tag, "_sof_eof"}, {30'd0, bus.dst_sof, bus.dst_eof}, 0);
        chk({tag, "_err"}, {29'd0, bus.err}, 0);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 0);
        chk({tag, "_filt_in"}, {23'd0, bus.filt_frame_sync_in, bus.filt_data_in}, 0);
    endtask

    initial begin
        int frames_before, n;
        bus.err_clr = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk); #2 rst = 1'b0;

        // single frame from src0
        @(posedge clk); #1 req_total[0]++;
        wait_idle(2000);
        chk("t1_frames", frames_done, 1);
        chk("t1_err", {29'd0, bus.err}, 0);

        // both sources requesting: round-robin alternation
        @(posedge clk); #1 req_total[0] += 2; req_total[1] += 1;
        wait_idle(3000);
        chk("t2_frames", frames_done, 4);

        // three frames outstanding before the first output returns
        @(posedge clk); #1 req_total[0] += 1; req_total[1] += 2;
        wait_idle(3000);
        chk("t3_fifo_filled", max_out, 2);
        chk("t3_grant_withheld", {31'd0, withheld > 0}, 1);

        // randomized request bursts
        for (int it = 0; it < 6; it++) begin
            repeat ($urandom_range(0, 25)) @(posedge clk);
            #1 req_total[$urandom_range(0, 1)] += $urandom_range(1, 2);
        end
        wait_idle(6000);
        chk("rand_err", {29'd0, bus.err}, 0);

        // underrun at pixel 5
        frames_before = frames_done;
        inv_frame_no = granted_total; inv_idx = 5;
        @(posedge clk); #1 req_total[1]++;
        wait_idle(2000);
        inv_frame_no = -1;
        chk("underrun_err", {29'd0, bus.err}, 3'b001);
        chk("underrun_frames", frames_done - frames_before, 1);
        pulse_clr();
        chk("underrun_clr", {29'd0, bus.err}, 0);

        // orphan filter frame
        @(posedge clk); #1 inject_req++;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1 chk("orphan_dst", {30'd0, bus.dst_valid}, 0);
        end
        chk("orphan_err", {29'd0, bus.err}, 3'b010);
        pulse_clr();
        chk("orphan_clr", {29'd0, bus.err}, 0);

        // reset in the middle of an output frame
        @(posedge clk); #1 req_total[0]++;
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!(mon_active != 0 && mon_idx == 7) && n < 2000);
        chk("reset_reach_px7", {31'd0, n < 2000}, 1);
        #1 rst = 1'b1;
        #1 check_all_zero("async_reset");
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1 req_total[0]++; req_total[1]++;
        wait_idle(3000);
        chk("post_reset_first_grant", first_owner, 0);
        chk("sync_in_per_grant", sync_in_total, granted_total);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end
endmodule
